// File: rtl/if_spi_slave.sv
// Byte-oriented SPI mode-0 slave, MSB first, with RX and TX FIFOs on the host side.
// The SPI pins are oversampled on clk; the master must keep sclk at or below clk/8.
module if_spi_slave #(
    parameter int         DEPTH     = 64,
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] in_data,
    input  logic       in_ena,
    input  logic       rd_req,
    output logic [7:0] out_data,
    output logic       have_msg,
    output logic [7:0] len,
    output logic       rx_overflow,
    output logic       tx_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Stages [0],[1] synchronise; [2] is the history bit used for edge detection.
    logic [2:0] cs_sync_q;
    logic [2:0] sclk_sync_q;
    logic [1:0] mosi_sync_q;

    logic [0:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    tx_sr_q, tx_sr_d;
    logic [7:0]    rx_sr_q, rx_sr_d;
    logic          rx_ovf_q, tx_ovf_q;

    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_q, rx_rd_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;

    logic cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_s;
    logic tx_load, rx_push;
    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_pop, rx_wr_en, tx_pop, tx_wr_en;
    logic [7:0] rx_byte;

    assign cs_rise   =  cs_sync_q[1]   & ~cs_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1]   &  cs_sync_q[2];
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign mosi_s    =  mosi_sync_q[1];

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CW'(DEPTH));

    assign rx_byte  = {rx_sr_q[6:0], mosi_s};
    assign rx_pop   = rd_req & ~rx_empty;
    assign rx_wr_en = rx_push & (~rx_full | rx_pop);
    assign tx_pop   = tx_load & ~tx_empty;
    assign tx_wr_en = in_ena & (~tx_full | tx_pop);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        tx_load   = 1'b0;
        rx_push   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = 3'd0;
                if (cs_fall) begin
                    state_d = ST_ACTIVE;
                    tx_load = 1'b1;
                end
            end
            default: begin
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                end else if (sclk_rise) begin
                    rx_sr_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    rx_push   = (bit_cnt_q == 3'd7);
                end else if (sclk_fall) begin
                    if (bit_cnt_q == 3'd0) tx_load = 1'b1;
                    else                   tx_sr_d = {tx_sr_q[6:0], 1'b0};
                end
            end
        endcase
        if (tx_load) tx_sr_d = tx_empty ? IDLE_BYTE : tx_mem[tx_rd_q];
    end

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        case ({rx_wr_en, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
        tx_cnt_d = tx_cnt_q;
        case ({tx_wr_en, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            rx_cnt_q    <= '0;
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            tx_cnt_q    <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[1:0], cs_n};
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            if (rx_push & rx_full & ~rx_pop) rx_ovf_q <= 1'b1;
            if (in_ena & tx_full & ~tx_pop)  tx_ovf_q <= 1'b1;
            if (rx_wr_en) rx_wr_q <= rx_wr_q + AW'(1);
            if (rx_pop)   rx_rd_q <= rx_rd_q + AW'(1);
            if (tx_wr_en) tx_wr_q <= tx_wr_q + AW'(1);
            if (tx_pop)   tx_rd_q <= tx_rd_q + AW'(1);
        end
    end

    // NOTE: FIFO storage is not reset; the counts guard every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (rx_wr_en) rx_mem[rx_wr_q] <= rx_byte;
        if (tx_wr_en) tx_mem[tx_wr_q] <= in_data;
    end

    assign miso        = (state_q == ST_ACTIVE) & tx_sr_q[7];
    assign have_msg    = (state_q == ST_IDLE) & ~rx_empty;
    assign len         = 8'(rx_cnt_q);
    assign out_data    = rx_empty ? 8'h00 : rx_mem[rx_rd_q];
    assign rx_overflow = rx_ovf_q;
    assign tx_overflow = tx_ovf_q;

endmodule

// File: tb/tb_if_spi_slave.sv
// Self-checking bench for if_spi_slave: a queue-based model of the FIFOs and frames,
// a per-cycle compare process, directed scenarios and randomized frames.
module tb_if_spi_slave;

    localparam int         DEPTH = 16;
    localparam logic [7:0] IDLE  = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic       miso;
    logic [7:0] in_data = 8'h00;
    logic       in_ena = 1'b0, rd_req = 1'b0;
    logic [7:0] out_data, len;
    logic       have_msg, rx_overflow, tx_overflow;

    always #5 clk = ~clk;

    if_spi_slave #(.DEPTH(DEPTH), .IDLE_BYTE(IDLE)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso),
        .in_data(in_data), .in_ena(in_ena), .rd_req(rd_req), .out_data(out_data),
        .have_msg(have_msg), .len(len), .rx_overflow(rx_overflow), .tx_overflow(tx_overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: host-visible FIFO contents and sticky flags.
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    bit         m_rx_ovf = 1'b0, m_tx_ovf = 1'b0;
    bit         model_valid = 1'b0, in_frame = 1'b0;

    logic [7:0] mosi_q[$];
    logic [7:0] got_q[$];
    logic [7:0] v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_take();
        if (m_tx.size() > 0) return m_tx.pop_front();
        return IDLE;
    endfunction

    always @(negedge clk) begin
        if (!rst && model_valid) begin
            check("len", len, m_rx.size());
            check("have_msg", have_msg, m_rx.size() != 0);
            if (m_rx.size() != 0) check("out_data", out_data, m_rx[0]);
            check("rx_overflow", rx_overflow, m_rx_ovf);
            check("tx_overflow", tx_overflow, m_tx_ovf);
            check("miso_idle", miso, 1'b0);
        end
        if (!rst && in_frame) check("have_msg_in_frame", have_msg, 1'b0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input logic [7:0] d);
        @(negedge clk);
        in_data = d;
        in_ena  = 1'b1;
        @(posedge clk);
        #1;
        in_ena = 1'b0;
        if (m_tx.size() < DEPTH) m_tx.push_back(d);
        else                     m_tx_ovf = 1'b1;
    endtask

    task automatic host_read(output logic [7:0] d);
        @(negedge clk);
        d      = out_data;
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        if (m_rx.size() > 0) void'(m_rx.pop_front());
    endtask

    // Master side of one frame: nfull whole bytes, then npart bits of one more byte.
    // rst_bit >= 0 pulses rst after that rising edge of the partial byte.
    task automatic frame(input int nfull, input int npart, input int rst_bit);
        logic [7:0] exp_q[$];
        logic [7:0] cur;
        int nbytes, nb;
        nbytes = nfull + ((npart > 0) ? 1 : 0);
        got_q.delete();
        model_valid = 1'b0;
        for (int k = 0; k <= nfull; k++) exp_q.push_back(m_take());
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(8);
        in_frame = 1'b1;
        for (int b = 0; b < nbytes; b++) begin
            nb  = (b < nfull) ? 8 : npart;
            cur = 8'h00;
            for (int i = 0; i < nb; i++) begin
                mosi = mosi_q[b][7-i];
                wait_clk(8);
                cur  = {cur[6:0], miso};
                sclk = 1'b1;
                if (rst_bit >= 0 && b == nfull && i == rst_bit) begin
                    rst = 1'b1;
                    wait_clk(2);
                    rst = 1'b0;
                    in_frame = 1'b0;
                end
                wait_clk(8);
                sclk = 1'b0;
            end
            if (b < nfull) got_q.push_back(cur);
        end
        wait_clk(8);
        in_frame = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(10);
        for (int b = 0; b < nfull; b++) begin
            check($sformatf("miso_byte%0d", b), got_q[b], exp_q[b]);
            if (m_rx.size() < DEPTH) m_rx.push_back(mosi_q[b]);
            else                     m_rx_ovf = 1'b1;
        end
        if (rst_bit >= 0) begin
            m_tx.delete();
            m_rx.delete();
            m_rx_ovf = 1'b0;
            m_tx_ovf = 1'b0;
        end
        model_valid = 1'b1;
    endtask

    initial begin
        wait_clk(4);
        rst = 1'b0;
        wait_clk(1);
        check("rst_miso", miso, 1'b0);
        check("rst_have_msg", have_msg, 1'b0);
        check("rst_len", len, 8'd0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_rx_ovf", rx_overflow, 1'b0);
        check("rst_tx_ovf", tx_overflow, 1'b0);
        model_valid = 1'b1;
        wait_clk(20);

        // Single byte with TX empty.
        mosi_q = '{8'hA5};
        frame(1, 0, -1);
        check("single_miso", got_q[0], 8'h00);
        check("single_have_msg", have_msg, 1'b1);
        check("single_len", len, 8'd1);
        check("single_out", out_data, 8'hA5);
        host_read(v);
        check("single_read", v, 8'hA5);
        wait_clk(1);
        check("single_have_msg_after", have_msg, 1'b0);
        check("single_len_after", len, 8'd0);

        // Three-byte full duplex.
        host_write(8'h11);
        host_write(8'h22);
        host_write(8'h33);
        mosi_q = '{8'hDE, 8'hAD, 8'hBE};
        frame(3, 0, -1);
        check("fd_miso0", got_q[0], 8'h11);
        check("fd_miso1", got_q[1], 8'h22);
        check("fd_miso2", got_q[2], 8'h33);
        check("fd_len", len, 8'd3);
        host_read(v); check("fd_read0", v, 8'hDE);
        host_read(v); check("fd_read1", v, 8'hAD);
        host_read(v); check("fd_read2", v, 8'hBE);

        // Abort after 5 bits of the second byte, then an aligned frame.
        mosi_q = '{8'h3C, 8'hF0};
        frame(1, 5, -1);
        check("abort_len", len, 8'd1);
        check("abort_out", out_data, 8'h3C);
        mosi_q = '{8'h96};
        frame(1, 0, -1);
        check("realign_len", len, 8'd2);
        host_read(v); check("realign_read0", v, 8'h3C);
        host_read(v); check("realign_read1", v, 8'h96);

        // RX overflow: DEPTH+1 bytes in one frame, the last one is dropped.
        mosi_q.delete();
        for (int i = 0; i < DEPTH + 1; i++) mosi_q.push_back(8'(i + 1));
        frame(DEPTH + 1, 0, -1);
        check("rxovf_len", len, 8'(DEPTH));
        check("rxovf_flag", rx_overflow, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            host_read(v);
            check($sformatf("rxovf_read%0d", i), v, 8'(i + 1));
        end

        // TX overflow.
        for (int i = 0; i < DEPTH + 1; i++) host_write(8'(8'h80 + i));
        wait_clk(1);
        check("txovf_flag", tx_overflow, 1'b1);

        // Reset during the second byte; everything clears, then a clean frame.
        mosi_q = '{8'h33, 8'hCC};
        frame(1, 5, 2);
        check("midrst_miso0", got_q[0], 8'h80);
        check("midrst_len", len, 8'd0);
        check("midrst_have_msg", have_msg, 1'b0);
        check("midrst_rx_ovf", rx_overflow, 1'b0);
        check("midrst_tx_ovf", tx_overflow, 1'b0);
        mosi_q = '{8'h5A};
        frame(1, 0, -1);
        check("postrst_miso", got_q[0], IDLE);
        check("postrst_len", len, 8'd1);
        check("postrst_out", out_data, 8'h5A);
        host_read(v);

        // Randomized traffic against the model.
        for (int it = 0; it < 24; it++) begin
            int nw, nf, np, nr;
            nw = $urandom_range(0, 4);
            for (int i = 0; i < nw; i++) host_write(8'($urandom));
            nf = $urandom_range(1, 4);
            np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            mosi_q.delete();
            for (int i = 0; i < nf + 1; i++) mosi_q.push_back(8'($urandom));
            frame(nf, np, -1);
            nr = $urandom_range(0, m_rx.size());
            for (int i = 0; i < nr; i++) host_read(v);
        end
        wait_clk(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
